// File: rtl/rk16_intc_pkg.sv
// rk16_intc_pkg: shared types and constants for the RK16 interrupt controller.
// Optional build macro used by this block: RK16_INTC_RR_EN (round-robin selection).
package rk16_intc_pkg;

   // Upper bound on the number of request lines a controller instance may have.
   localparam int INTC_MAX_SRC = 16;

   // Controller states:
   //   IDLE    - waiting for an eligible pending request
   //   FIRE    - intr asserted toward the pfc, waiting for a committed step
   //   SERVICE - handler running, waiting for an iret step
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FIRE    = 2'd1,
      SERVICE = 2'd2
   } intc_state_t;

endpackage

// File: rtl/rk16_intc_arb.sv
// rk16_intc_arb: combinational request selector for rk16_intc.
// Scans the request vector starting at ptr, wrapping modulo N_SRC, and grants
// the first set bit.  A constant ptr of 0 gives fixed lowest-index priority.
module rk16_intc_arb #(
   parameter int N_SRC = 4,
   parameter int CW    = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [CW-1:0]    ptr,
   output logic             gnt_valid,
   output logic [CW-1:0]    gnt_idx
);

   int j;

   // Rotating scan: first requester at or after ptr wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      j         = 0;
      for (int k = 0; k < N_SRC; k++) begin
         j = (int'(ptr) + k) % N_SRC;
         if (!gnt_valid && req[j]) begin
            gnt_valid = 1'b1;
            gnt_idx   = CW'(j);
         end
      end
   end

endmodule

// File: rtl/rk16_intc.sv
// rk16_intc: interrupt controller between peripheral request lines and the
// RK16 program flow controller.  Rising edges on irq are latched into pending,
// qualified by mask and the global enable ie, and one source is selected and
// signalled on intr.  Build macro RK16_INTC_RR_EN selects round-robin instead
// of fixed lowest-index priority; ports and timing are the same either way.
//
// Handshake with the pfc: intr is a registered request that stays high while
// in FIRE; the pfc accepts it on the first rising edge with step=1, after which
// intr drops and busy rises.  The handler ends service with a step that also
// carries iret=1; iret without step, or outside SERVICE, has no effect.
module rk16_intc
   import rk16_intc_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int CW    = $clog2(N_SRC)
) (
   input  logic             clk_pc,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] irq,
   input  logic             step,
   input  logic             iret,
   input  logic             ie_we,
   input  logic             ie_wdata,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_wdata,
   output logic             intr,
   output logic [CW-1:0]    cause,
   output logic             busy,
   output logic [N_SRC-1:0] pending,
   output logic [1:0]       state_dbg
);

   intc_state_t      state;
   intc_state_t      state_nxt;
   logic [N_SRC-1:0] irq_q;
   logic [N_SRC-1:0] mask;
   logic             ie;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] eligible;
   logic [N_SRC-1:0] pending_nxt;
   logic [CW-1:0]    arb_ptr;
   logic             gnt_valid;
   logic [CW-1:0]    gnt_idx;
   logic             take;

   assign rise     = irq & ~irq_q;
   assign eligible = pending & mask;
   assign state_dbg = state;

`ifdef RK16_INTC_RR_EN
   // Search begins just past the most recently serviced source; cause only
   // changes on FIRE entry, so the pointer advances exactly then.
   assign arb_ptr = (cause == CW'(N_SRC - 1)) ? '0 : cause + CW'(1);
`else
   // Fixed priority: always start the scan at source 0.
   assign arb_ptr = '0;
`endif

   rk16_intc_arb #(
      .N_SRC (N_SRC),
      .CW    (CW)
   ) u_arb (
      .req       (eligible),
      .ptr       (arb_ptr),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // Next-state decode; take marks the IDLE->FIRE transition.
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         IDLE: begin
            if (ie && gnt_valid) begin
               take      = 1'b1;
               state_nxt = FIRE;
            end
         end
         FIRE: begin
            if (step) begin
               state_nxt = SERVICE;
            end
         end
         SERVICE: begin
            if (step && iret) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pending update: clear the granted bit, then OR in new rises so a rise
   // coinciding with the clear of the same bit keeps it set.
   always_comb begin
      pending_nxt = pending;
      if (take) begin
         pending_nxt[gnt_idx] = 1'b0;
      end
      pending_nxt = pending_nxt | rise;
   end

   // Edge-detect history; zero at reset so a line high out of reset pends once.
   always_ff @(posedge clk_pc or negedge rst_n) begin
      if (!rst_n) begin
         irq_q <= '0;
      end else begin
         irq_q <= irq;
      end
   end

   // Software-visible configuration; new values steer the next cycle's decision.
   always_ff @(posedge clk_pc or negedge rst_n) begin
      if (!rst_n) begin
         mask <= '0;
         ie   <= 1'b0;
      end else begin
         if (mask_we) begin
            mask <= mask_wdata;
         end
         if (ie_we) begin
            ie <= ie_wdata;
         end
      end
   end

   // Latched requests awaiting service.
   always_ff @(posedge clk_pc or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_pc or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Serviced-source index, captured on FIRE entry and held until the next one.
   always_ff @(posedge clk_pc or negedge rst_n) begin
      if (!rst_n) begin
         cause <= '0;
      end else if (take) begin
         cause <= gnt_idx;
      end
   end

   // intr and busy come straight from flops so they never glitch.
   always_ff @(posedge clk_pc or negedge rst_n) begin
      if (!rst_n) begin
         intr <= 1'b0;
         busy <= 1'b0;
      end else begin
         intr <= (state_nxt == FIRE);
         busy <= (state_nxt == SERVICE);
      end
   end

endmodule

// File: tb/tb_rk16_intc.sv
// tb_rk16_intc: self-checking bench for rk16_intc (N_SRC=4).
// Define RK16_INTC_RR_EN on both bench and RTL to check the round-robin build.
module tb_rk16_intc;

   localparam int N_SRC = 4;
   localparam int CW    = 2;

   logic             clk_pc = 1'b0;
   logic             rst_n;
   logic [N_SRC-1:0] irq;
   logic             step;
   logic             iret;
   logic             ie_we;
   logic             ie_wdata;
   logic             mask_we;
   logic [N_SRC-1:0] mask_wdata;
   logic             intr;
   logic [CW-1:0]    cause;
   logic             busy;
   logic [N_SRC-1:0] pending;
   logic [1:0]       state_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboard: expected cause for each intr assertion, in order.
   logic [CW-1:0] exp_q[$];
   logic [CW-1:0] exp_c;
   logic          intr_prev = 1'b0;

   rk16_intc #(.N_SRC(N_SRC), .CW(CW)) dut (
      .clk_pc     (clk_pc),
      .rst_n      (rst_n),
      .irq        (irq),
      .step       (step),
      .iret       (iret),
      .ie_we      (ie_we),
      .ie_wdata   (ie_wdata),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .intr       (intr),
      .cause      (cause),
      .busy       (busy),
      .pending    (pending),
      .state_dbg  (state_dbg)
   );

   // Clock / reset block
   always #5 clk_pc = ~clk_pc;

   // Scoreboard monitor: each rising intr must match the oldest expected cause.
   always @(posedge clk_pc) begin
      #3;
      if (!rst_n) begin
         intr_prev = 1'b0;
      end else begin
         if (intr && !intr_prev) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected_intr: got intr with cause=%0d, required no intr", cause);
            end else begin
               exp_c = exp_q.pop_front();
               if (cause !== exp_c) begin
                  n_fail++;
                  $display("FAIL sb_cause: got %0d, required %0d", cause, exp_c);
               end
            end
         end
         intr_prev = intr;
      end
   end

   // Driver tasks
   task automatic cyc(input int n);
      repeat (n) @(posedge clk_pc);
      #1;
   endtask

   task automatic wr_mask(input logic [N_SRC-1:0] v);
      mask_wdata = v;
      mask_we    = 1'b1;
      cyc(1);
      mask_we    = 1'b0;
   endtask

   task automatic wr_ie(input logic v);
      ie_wdata = v;
      ie_we    = 1'b1;
      cyc(1);
      ie_we    = 1'b0;
   endtask

   task automatic pulse_irq(input logic [N_SRC-1:0] v);
      irq = v;
      cyc(1);
      irq = '0;
   endtask

   task automatic step_once(input logic iret_v);
      step = 1'b1;
      iret = iret_v;
      cyc(1);
      step = 1'b0;
      iret = 1'b0;
   endtask

   // Tests
   task automatic test_reset();
      rst_n = 1'b0; irq = '0; step = 1'b0; iret = 1'b0;
      ie_we = 1'b0; ie_wdata = 1'b0; mask_we = 1'b0; mask_wdata = '0;
      cyc(2);
      n_tests++; if (intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %0b, required 0", intr); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, required 0", busy); end
      n_tests++; if (cause !== 2'd0) begin n_fail++; $display("FAIL reset_cause: got %0d, required 0", cause); end
      n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b, required 0000", pending); end
      n_tests++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", state_dbg); end
      rst_n = 1'b1;
      cyc(1);
      wr_ie(1'b1);
      wr_mask(4'b1111);
   endtask

   task automatic test_single();
      exp_q.push_back(2'd2);
      pulse_irq(4'b0100);
      n_tests++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL single_pending: got %b, required 0100", pending); end
      n_tests++; if (intr !== 1'b0) begin n_fail++; $display("FAIL single_intr_early: got %0b, required 0", intr); end
      cyc(1);
      n_tests++; if (intr !== 1'b1) begin n_fail++; $display("FAIL single_intr: got %0b, required 1", intr); end
      n_tests++; if (cause !== 2'd2) begin n_fail++; $display("FAIL single_cause: got %0d, required 2", cause); end
      n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL single_pending_clr: got %b, required 0000", pending); end
      n_tests++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL single_state_fire: got %0d, required 1", state_dbg); end
      step_once(1'b0);
      n_tests++; if (intr !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_service: got intr=%0b busy=%0b, required intr=0 busy=1", intr, busy); end
      step_once(1'b1);
      n_tests++; if (busy !== 1'b0 || state_dbg !== 2'd0) begin n_fail++; $display("FAIL single_iret: got busy=%0b state=%0d, required busy=0 state=0", busy, state_dbg); end
   endtask

   task automatic test_priority();
      logic [CW-1:0]    first_c;
      logic [CW-1:0]    second_c;
      logic [N_SRC-1:0] left;
`ifdef RK16_INTC_RR_EN
      // last cause is 2, so the scan starts at 3
      first_c  = 2'd3;
      second_c = 2'd1;
`else
      first_c  = 2'd1;
      second_c = 2'd3;
`endif
      left = 4'b1010 & ~(4'b0001 << first_c);
      exp_q.push_back(first_c);
      exp_q.push_back(second_c);
      pulse_irq(4'b1010);
      n_tests++; if (pending !== 4'b1010) begin n_fail++; $display("FAIL prio_pending: got %b, required 1010", pending); end
      cyc(1);
      n_tests++; if (intr !== 1'b1 || cause !== first_c) begin n_fail++; $display("FAIL prio_first: got intr=%0b cause=%0d, required 1/%0d", intr, cause, first_c); end
      n_tests++; if (pending !== left) begin n_fail++; $display("FAIL prio_left: got %b, required %b", pending, left); end
      step_once(1'b0);
      step_once(1'b1);
      n_tests++; if (intr !== 1'b0 || state_dbg !== 2'd0) begin n_fail++; $display("FAIL prio_idle: got intr=%0b state=%0d, required 0/0", intr, state_dbg); end
      cyc(1);
      n_tests++; if (intr !== 1'b1 || cause !== second_c) begin n_fail++; $display("FAIL prio_second: got intr=%0b cause=%0d, required 1/%0d", intr, cause, second_c); end
      n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL prio_pending_clr: got %b, required 0000", pending); end
      step_once(1'b0);
      step_once(1'b1);
   endtask

   task automatic test_step_hold();
      exp_q.push_back(2'd0);
      pulse_irq(4'b0001);
      cyc(1);
      for (int i = 0; i < 5; i++) begin
         iret = 1'b1;
         cyc(1);
         n_tests++; if (intr !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL hold_intr[%0d]: got intr=%0b busy=%0b, required 1/0", i, intr, busy); end
      end
      iret = 1'b0;
      step_once(1'b1);
      n_tests++; if (intr !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL hold_step: got intr=%0b busy=%0b, required 0/1", intr, busy); end
      step_once(1'b0);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_step_no_iret: got busy=%0b, required 1", busy); end
      step_once(1'b1);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_iret: got busy=%0b, required 0", busy); end
   endtask

   task automatic test_mask();
      wr_mask(4'b0000);
      pulse_irq(4'b0001);
      n_tests++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL mask_pending: got %b, required 0001", pending); end
      cyc(3);
      n_tests++; if (intr !== 1'b0 || pending !== 4'b0001) begin n_fail++; $display("FAIL mask_blocked: got intr=%0b pending=%b, required 0/0001", intr, pending); end
      exp_q.push_back(2'd0);
      wr_mask(4'b0001);
      n_tests++; if (intr !== 1'b0) begin n_fail++; $display("FAIL mask_write_cycle: got %0b, required 0", intr); end
      cyc(1);
      n_tests++; if (intr !== 1'b1 || cause !== 2'd0) begin n_fail++; $display("FAIL mask_fire: got intr=%0b cause=%0d, required 1/0", intr, cause); end
      step_once(1'b0);
      step_once(1'b1);
      wr_mask(4'b1111);
   endtask

   task automatic test_nest();
      exp_q.push_back(2'd1);
      pulse_irq(4'b0010);
      cyc(1);
      step_once(1'b0);
      exp_q.push_back(2'd0);
      pulse_irq(4'b0001);
      n_tests++; if (pending !== 4'b0001 || busy !== 1'b1 || intr !== 1'b0) begin n_fail++; $display("FAIL nest_pend: got pending=%b busy=%0b intr=%0b, required 0001/1/0", pending, busy, intr); end
      cyc(3);
      n_tests++; if (intr !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL nest_hold: got intr=%0b busy=%0b, required 0/1", intr, busy); end
      step_once(1'b1);
      n_tests++; if (intr !== 1'b0 || busy !== 1'b0 || pending !== 4'b0001) begin n_fail++; $display("FAIL nest_iret: got intr=%0b busy=%0b pending=%b, required 0/0/0001", intr, busy, pending); end
      cyc(1);
      n_tests++; if (intr !== 1'b1 || cause !== 2'd0) begin n_fail++; $display("FAIL nest_fire: got intr=%0b cause=%0d, required 1/0", intr, cause); end
      step_once(1'b0);
      step_once(1'b1);
   endtask

   task automatic test_back_to_back();
      exp_q.push_back(2'd1);
      pulse_irq(4'b0010);
      cyc(1);
      step_once(1'b0);
      exp_q.push_back(2'd2);
      pulse_irq(4'b0100);
      n_tests++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL b2b_pending: got %b, required 0100", pending); end
      step_once(1'b1);
      // new rise on source 2 lands on the same edge that clears its bit
      irq = 4'b0100;
      cyc(1);
      irq = '0;
      exp_q.push_back(2'd2);
      n_tests++; if (intr !== 1'b1 || cause !== 2'd2) begin n_fail++; $display("FAIL b2b_fire: got intr=%0b cause=%0d, required 1/2", intr, cause); end
      n_tests++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL b2b_set_wins: got %b, required 0100", pending); end
      step_once(1'b0);
      step_once(1'b1);
      cyc(1);
      n_tests++; if (intr !== 1'b1 || pending !== 4'b0000) begin n_fail++; $display("FAIL b2b_refire: got intr=%0b pending=%b, required 1/0000", intr, pending); end
      step_once(1'b0);
      step_once(1'b1);
   endtask

   task automatic test_reset_mid();
      exp_q.push_back(2'd2);
      pulse_irq(4'b0100);
      cyc(1);
      step_once(1'b0);
      pulse_irq(4'b1010);
      n_tests++; if (pending !== 4'b1010 || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_setup: got pending=%b busy=%0b, required 1010/1", pending, busy); end
      #3;
      rst_n = 1'b0;
      #1;
      n_tests++; if (intr !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got intr=%0b busy=%0b, required 0/0", intr, busy); end
      n_tests++; if (pending !== 4'b0000 || cause !== 2'd0 || state_dbg !== 2'd0) begin n_fail++; $display("FAIL rmid_clear: got pending=%b cause=%0d state=%0d, required 0000/0/0", pending, cause, state_dbg); end
      cyc(1);
      rst_n = 1'b1;
      cyc(3);
      n_tests++; if (intr !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got %0b, required 0", intr); end
      wr_mask(4'b1111);
      pulse_irq(4'b1000);
      cyc(3);
      n_tests++; if (intr !== 1'b0 || pending !== 4'b1000) begin n_fail++; $display("FAIL rmid_ie_off: got intr=%0b pending=%b, required 0/1000", intr, pending); end
      exp_q.push_back(2'd3);
      wr_ie(1'b1);
      n_tests++; if (intr !== 1'b0) begin n_fail++; $display("FAIL rmid_ie_write_cycle: got %0b, required 0", intr); end
      cyc(1);
      n_tests++; if (intr !== 1'b1 || cause !== 2'd3) begin n_fail++; $display("FAIL rmid_fire: got intr=%0b cause=%0d, required 1/3", intr, cause); end
      step_once(1'b0);
      step_once(1'b1);
   endtask

   // Sequencer and final report
   initial begin
      test_reset();
      test_single();
      test_priority();
      test_step_hold();
      test_mask();
      test_nest();
      test_back_to_back();
      test_reset_mid();
      cyc(4);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d expected interrupts outstanding, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rk16_intc.md
# rk16_intc

Interrupt controller for the RK16 core, sitting between peripheral interrupt lines and the program flow controller (pfc). It captures rising edges on up to N_SRC request lines, applies a per-source mask and a global enable, and selects one source. It drives the pfc `intr` input for exactly one committed instruction step, then holds off further interrupts until the handler executes `iret`. Software reads `cause` to identify the serviced source.

## Interface
- N_SRC, 4, number of interrupt request lines (2..16)
- CW, $clog2(N_SRC), width of `cause`

- clk_pc  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- irq  in  N_SRC  peripheral requests, synchronous to clk_pc, edge-detected
- step  in  1  core commits an instruction (pc advances) at this edge
- iret  in  1  handler return, sampled only when `step`=1
- ie_we / ie_wdata  in  1 / 1  global enable write
- mask_we / mask_wdata  in  1 / N_SRC  mask write, 1 = enabled
- intr  out  1  to pfc; interrupt taken at the next edge with `step`=1
- cause  out  CW  index of the source being or last serviced
- busy  out  1  handler in service
- pending  out  N_SRC  latched, unserviced requests

## Operation
- Edge detect: `irq_q` <= `irq`; rise = `irq & ~irq_q`; rise sets `pending[i]`. `irq_q` resets to 0, so a line held high out of reset produces one rise.
- Eligible = `pending & mask`, qualified by `ie`.
- States: IDLE, FIRE, SERVICE.
  - IDLE: if `ie` and eligible != 0 -> FIRE; latch the selected index into `cause`; clear that `pending` bit.
  - FIRE: `intr`=1; hold until `step`=1 -> SERVICE.
  - SERVICE: `busy`=1; `step`&`iret` -> IDLE.
- Selection: fixed priority, lowest index wins.
- Simultaneous events on one source: a rise in the same cycle as the clear of that bit re-sets the bit (set wins).
- Writes to `mask` or `ie` take effect for the next cycle's decision; the current cycle decides with the old values.
- FIRE is not cancelled by a later mask or ie write; the interrupt is still delivered.
- `iret` in IDLE or FIRE is ignored.
- No nesting: new rises only pend during FIRE and SERVICE.

## Timing
- Reset values:
  - state IDLE; `intr` 0; `busy` 0; `cause` 0; `pending` 0; `mask` 0; `ie` 0; `irq_q` 0.
- Latency, with `ie`=1 and the source unmasked:
  - rise on `irq` sampled at edge n -> `pending` visible in cycle n+1;
  - FIRE entered at edge n+1 -> `intr` high from cycle n+2.
- `intr` is registered (state==FIRE only) and never glitches.
- `intr` drops the cycle after the first `step` edge in FIRE.
- Back-to-back: `iret` step at edge m -> IDLE at m; the next eligible source can be in FIRE at m+1.
- Reset asserted mid-FIRE or mid-SERVICE: all state clears immediately and `intr` drops asynchronously.

## Configuration
- `RK16_INTC_RR_EN`:
  - Defined: round-robin selection. The search starts at (last `cause`+1) mod N_SRC, and the pointer advances on each FIRE entry.
  - Undefined: fixed lowest-index priority as above.
- Ports and timing are identical in both builds.

## Structure
- Shared package `rk16_intc_pkg`:
  - `intc_state_t` enum (IDLE, FIRE, SERVICE);
  - `INTC_MAX_SRC`=16 constant.
- Sub-module `rk16_intc_arb`:
  - Purely combinational selector: inputs request vector and start pointer; outputs grant valid and index.
  - Fixed priority forces the pointer to 0.
- Top: edge detect, pending/mask/ie registers, FSM, output registers.

## Test plan
- Reset with `irq`=4'b0000, `ie`=1, `mask`=4'b1111; pulse `irq[2]` one cycle -> `pending`=4'b0100 next cycle, `intr`=1 one cycle later, `cause`=2, `pending`=0.
- `irq[1]` and `irq[3]` rise together, fixed priority -> `cause`=1 first; after `iret` step, second FIRE with `cause`=3. With `RK16_INTC_RR_EN` and last `cause`=1 -> 3 first.
- `step`=0 held 5 cycles in FIRE -> `intr` stays 1; `step`=1 -> `intr`=0 next cycle, `busy`=1.
- `mask`=4'b0000 with a pending `irq[0]` -> no `intr`; write `mask`=4'b0001 -> `intr` asserted 2 cycles after the write.
- Rise on `irq[0]` during SERVICE -> `pending[0]`=1, no `intr` until `iret` step, then FIRE next cycle.
- `rst_n` low mid-SERVICE with `pending`=4'b1010 -> all outputs 0 immediately; after release `intr` stays 0 until `ie` is written.
